// File: rtl/tile_map_pkg.sv
// Shared constants and types for the kitchen-grid tile mapper.
// Holds the default grid geometry, the mapper FSM state type and the
// registered response record. The response record is sized for the
// default grid; the top level casts into and out of it.
package tile_map_pkg;

    localparam int DEF_COORD_W   = 10;
    localparam int DEF_ORIGIN_X  = 20;
    localparam int DEF_ORIGIN_Y  = 100;
    localparam int DEF_TILE_W    = 40;
    localparam int DEF_TILE_H    = 40;
    localparam int DEF_GRID_COLS = 15;
    localparam int DEF_GRID_ROWS = 9;

    localparam int DEF_IDX_W = $clog2(DEF_GRID_COLS * DEF_GRID_ROWS + 1);
    localparam int DEF_COL_W = $clog2(DEF_GRID_COLS + 1);
    localparam int DEF_ROW_W = $clog2(DEF_GRID_ROWS + 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, RESP} tile_map_state_t;

    typedef struct packed {
        logic [DEF_COL_W-1:0]   col;
        logic [DEF_ROW_W-1:0]   row;
        logic [DEF_IDX_W-1:0]   index;
        logic [DEF_COORD_W-1:0] off_x;
        logic [DEF_COORD_W-1:0] off_y;
        logic                   in_bounds;
    } tile_resp_t;

endpackage

// File: rtl/tile_axis_divider.sv
// One axis of the pixel-to-tile mapping: subtract-and-count division.
// Ports:
//   Clk, Reset  clock, synchronous active-high reset
//   load        capture coord (coord - ORIGIN), clear the count
//   coord       pixel coordinate
//   step_en     allow one subtract step this cycle
//   rem         running remainder (pixel offset inside tile once done)
//   cnt         tiles counted so far (column or row)
//   done        remainder below one tile, or count reached the grid edge
//   oob         coordinate left of/above origin, or beyond the last tile
module tile_axis_divider #(
    parameter int COORD_W = 10,
    parameter int CNT_W   = 4,
    parameter int TILE    = 40,
    parameter int GRID    = 15,
    parameter int ORIGIN  = 20
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               load,
    input  logic [COORD_W-1:0] coord,
    input  logic               step_en,
    output logic [COORD_W-1:0] rem,
    output logic [CNT_W-1:0]   cnt,
    output logic               done,
    output logic               oob
);
    logic [COORD_W:0] diff;
    logic             borrow_q;
    logic             full;

    // One extra bit so the MSB acts as the borrow for coord < ORIGIN.
    assign diff = {1'b0, coord} - (COORD_W+1)'(ORIGIN);
    assign full = (cnt == CNT_W'(GRID));
    assign done = (rem < COORD_W'(TILE)) || full;
    assign oob  = borrow_q || full;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rem      <= '0;
            cnt      <= '0;
            borrow_q <= 1'b0;
        end else if (load) begin
            rem      <= diff[COORD_W-1:0];
            cnt      <= '0;
            borrow_q <= diff[COORD_W];
        end else if (step_en && !done) begin
            rem <= rem - COORD_W'(TILE);
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/tile_index_mapper.sv
// Shared pixel-to-tile mapper. NUM_CH requesters submit (x,y); the block
// returns column, row, linear tile index, in-tile offset and in-bounds flag.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   req_valid/ready   per-channel handshake, ready is a one-hot round-robin grant
//   req_x/req_y       packed coordinates, channel i at [i*COORD_W +: COORD_W]
//   resp_valid/ready  response handshake, response held until accepted
//   resp_ch           channel that issued the request
//   resp_col/row      tile coordinates
//   resp_index        col + row*GRID_COLS, all ones when out of bounds
//   resp_off_x/off_y  pixel offset inside the tile
//   resp_in_bounds    coordinate lies inside the grid
module tile_index_mapper
    import tile_map_pkg::*;
#(
    parameter int COORD_W   = DEF_COORD_W,
    parameter int ORIGIN_X  = DEF_ORIGIN_X,
    parameter int ORIGIN_Y  = DEF_ORIGIN_Y,
    parameter int TILE_W    = DEF_TILE_W,
    parameter int TILE_H    = DEF_TILE_H,
    parameter int GRID_COLS = DEF_GRID_COLS,
    parameter int GRID_ROWS = DEF_GRID_ROWS,
    parameter int NUM_CH    = 2,
    localparam int IDX_W = $clog2(GRID_COLS * GRID_ROWS + 1),
    localparam int COL_W = $clog2(GRID_COLS + 1),
    localparam int ROW_W = $clog2(GRID_ROWS + 1),
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_CH-1:0]         req_valid,
    output logic [NUM_CH-1:0]         req_ready,
    input  logic [NUM_CH*COORD_W-1:0] req_x,
    input  logic [NUM_CH*COORD_W-1:0] req_y,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [CH_W-1:0]           resp_ch,
    output logic [COL_W-1:0]          resp_col,
    output logic [ROW_W-1:0]          resp_row,
    output logic [IDX_W-1:0]          resp_index,
    output logic [COORD_W-1:0]        resp_off_x,
    output logic [COORD_W-1:0]        resp_off_y,
    output logic                      resp_in_bounds
);
    tile_map_state_t   state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   cur_ch;
    logic [IDX_W-1:0]  idx_acc;
    tile_resp_t        resp_q;

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_ch;
    logic              found;
    int                j;
    logic              xfer;
    logic [COORD_W-1:0] cap_x, cap_y;

    logic [COORD_W-1:0] rem_x, rem_y;
    logic [COL_W-1:0]   cnt_x;
    logic [ROW_W-1:0]   cnt_y;
    logic               done_x, done_y, oob_x, oob_y;
    logic               in_div, step_x, step_y, oob;

    // First valid channel at or after the round-robin pointer, wrapping.
    always_comb begin
        grant    = '0;
        grant_ch = '0;
        found    = 1'b0;
        j        = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && req_valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                grant_ch = CH_W'(j);
            end
        end
    end

    assign req_ready = (state == IDLE && !Reset) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign cap_x     = req_x[grant_ch*COORD_W +: COORD_W];
    assign cap_y     = req_y[grant_ch*COORD_W +: COORD_W];

    assign in_div = (state == DIVIDE);
    assign step_x = in_div && !done_x;
    assign step_y = in_div && !done_y;
    assign oob    = oob_x || oob_y;

    tile_axis_divider #(
        .COORD_W(COORD_W), .CNT_W(COL_W), .TILE(TILE_W), .GRID(GRID_COLS), .ORIGIN(ORIGIN_X)
    ) u_div_x (
        .Clk(Clk), .Reset(Reset), .load(xfer), .coord(cap_x), .step_en(in_div),
        .rem(rem_x), .cnt(cnt_x), .done(done_x), .oob(oob_x)
    );

    tile_axis_divider #(
        .COORD_W(COORD_W), .CNT_W(ROW_W), .TILE(TILE_H), .GRID(GRID_ROWS), .ORIGIN(ORIGIN_Y)
    ) u_div_y (
        .Clk(Clk), .Reset(Reset), .load(xfer), .coord(cap_y), .step_en(in_div),
        .rem(rem_y), .cnt(cnt_y), .done(done_y), .oob(oob_y)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_ch     <= '0;
            idx_acc    <= '0;
            resp_valid <= 1'b0;
            resp_ch    <= '0;
            resp_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        cur_ch  <= grant_ch;
                        rr_ptr  <= (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;
                        idx_acc <= '0;
                        state   <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    // Column and row steps may land in the same cycle.
                    idx_acc <= idx_acc + (step_x ? IDX_W'(1) : '0)
                                       + (step_y ? IDX_W'(GRID_COLS) : '0);
                    if ((done_x && done_y) || oob) begin
                        resp_q.col       <= DEF_COL_W'(cnt_x);
                        resp_q.row       <= DEF_ROW_W'(cnt_y);
                        resp_q.index     <= oob ? '1 : DEF_IDX_W'(idx_acc);
                        resp_q.off_x     <= DEF_COORD_W'(rem_x);
                        resp_q.off_y     <= DEF_COORD_W'(rem_y);
                        resp_q.in_bounds <= !oob;
                        resp_ch          <= cur_ch;
                        resp_valid       <= 1'b1;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign resp_col       = COL_W'(resp_q.col);
    assign resp_row       = ROW_W'(resp_q.row);
    assign resp_index     = IDX_W'(resp_q.index);
    assign resp_off_x     = COORD_W'(resp_q.off_x);
    assign resp_off_y     = COORD_W'(resp_q.off_y);
    assign resp_in_bounds = resp_q.in_bounds;
endmodule

// File: tb/tb_tile_index_mapper.sv
// Bench for tile_index_mapper: directed corners, random coordinates against
// an arithmetic reference, round-robin order, back-pressure and mid-flight reset.
module tb_tile_index_mapper;
    localparam int OX = 20, OY = 100, TW = 40, TH = 40, GC = 15, GR = 9;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  req_valid, req_ready;
    logic [19:0] req_x, req_y;
    logic        resp_valid, resp_ready;
    logic        resp_ch;
    logic [3:0]  resp_col, resp_row;
    logic [7:0]  resp_index;
    logic [9:0]  resp_off_x, resp_off_y;
    logic        resp_in_bounds;

    int tests = 0;
    int fails = 0;

    tile_index_mapper dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ch(resp_ch),
        .resp_col(resp_col), .resp_row(resp_row), .resp_index(resp_index),
        .resp_off_x(resp_off_x), .resp_off_y(resp_off_y), .resp_in_bounds(resp_in_bounds)
    );

    always #5 Clk = ~Clk;

    // Reference: plain division of the origin-relative coordinate. Latency is
    // one cycle per tile counted on the slower axis plus one, cut short by
    // whichever axis first runs off the grid.
    function automatic void model(input int x, input int y, output int col, output int row,
                                  output int idx, output int offx, output int offy,
                                  output int inb, output int lat);
        int tx, ty;
        col = 0; row = 0; offx = 0; offy = 0;
        if (x < OX || y < OY) begin
            inb = 0; idx = 255; lat = 1;
            return;
        end
        col = (x - OX) / TW; offx = (x - OX) % TW;
        row = (y - OY) / TH; offy = (y - OY) % TH;
        tx  = (col >= GC) ? GC + 1 : col + 1;
        ty  = (row >= GR) ? GR + 1 : row + 1;
        lat = (tx > ty) ? tx : ty;
        if (col >= GC && tx < lat) lat = tx;
        if (row >= GR && ty < lat) lat = ty;
        inb = (col < GC && row < GR) ? 1 : 0;
        idx = inb ? col + row * GC : 255;
    endfunction

    task automatic set_req(input int ch, input int x, input int y);
        req_x[ch*10 +: 10] = 10'(x);
        req_y[ch*10 +: 10] = 10'(y);
        req_valid[ch]      = 1'b1;
    endtask

    task automatic wait_grant(input int ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            if (req_ready[ch]) begin ok = 1'b1; break; end
        end
        if (ok) begin
            @(posedge Clk); #1;
            req_valid[ch] = 1'b0;
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clk); #1;
            if (resp_valid) begin lat = i; break; end
        end
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        @(posedge Clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        set_req(0, 20, 100);
        set_req(1, 300, 300);
        repeat (3) @(posedge Clk);
        #1;
        tests++;
        if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %0b exp 0", resp_valid); end
        tests++;
        if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        tests++;
        if ({resp_ch, resp_col, resp_row, resp_index, resp_off_x, resp_off_y, resp_in_bounds} !== '0) begin
            fails++;
            $display("FAIL reset_resp_data got col%0d row%0d idx%0d offx%0d offy%0d inb%0b ch%0d exp all 0",
                     resp_col, resp_row, resp_index, resp_off_x, resp_off_y, resp_in_bounds, resp_ch);
        end
    endtask

    // Both channels are still valid from reset: ch0 wins, then ch1, then ch0 again.
    task automatic test_round_robin();
        int lat;
        Reset = 1'b0;
        @(negedge Clk);
        tests++;
        if (req_ready !== 2'b01) begin fails++; $display("FAIL rr_first_grant got %b exp 01", req_ready); end
        @(posedge Clk); #1;
        req_valid[0] = 1'b0;
        wait_resp(lat);
        tests++;
        if (lat !== 1 || resp_ch !== 1'b0 || resp_index !== 8'd0) begin
            fails++; $display("FAIL rr_ch0_resp got lat%0d ch%0d idx%0d exp lat1 ch0 idx0", lat, resp_ch, resp_index);
        end
        accept();
        @(negedge Clk);
        tests++;
        if (req_ready !== 2'b10) begin fails++; $display("FAIL rr_second_grant got %b exp 10", req_ready); end
        @(posedge Clk); #1;
        req_valid[1] = 1'b0;
        set_req(0, 60, 140);
        wait_resp(lat);
        tests++;
        if (lat !== 8 || resp_ch !== 1'b1 || resp_index !== 8'd82) begin
            fails++; $display("FAIL rr_ch1_resp got lat%0d ch%0d idx%0d exp lat8 ch1 idx82", lat, resp_ch, resp_index);
        end
        accept();
        @(negedge Clk);
        tests++;
        if (req_ready !== 2'b01) begin fails++; $display("FAIL rr_third_grant got %b exp 01", req_ready); end
        @(posedge Clk); #1;
        req_valid[0] = 1'b0;
        wait_resp(lat);
        tests++;
        if (lat !== 2 || resp_ch !== 1'b0 || resp_index !== 8'd16) begin
            fails++; $display("FAIL rr_ch0_again got lat%0d ch%0d idx%0d exp lat2 ch0 idx16", lat, resp_ch, resp_index);
        end
        accept();
    endtask

    task automatic test_mapping();
        int xs[6] = '{20, 619, 19, 620, 20, 1023};
        int ys[6] = '{100, 459, 100, 100, 99, 1023};
        int x, y, ch, lat;
        int col, row, idx, offx, offy, inb, elat;
        bit ok;
        for (int n = 0; n < 46; n++) begin
            if (n < 6) begin x = xs[n]; y = ys[n]; ch = 0; end
            else begin
                x  = int'($urandom_range(0, 700));
                y  = int'($urandom_range(60, 560));
                ch = int'($urandom_range(0, 1));
            end
            model(x, y, col, row, idx, offx, offy, inb, elat);
            set_req(ch, x, y);
            wait_grant(ch, ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL map_grant (%0d,%0d) ch%0d got no grant exp grant", x, y, ch); continue; end
            wait_resp(lat);
            tests++;
            if (lat !== elat) begin fails++; $display("FAIL map_latency (%0d,%0d) got %0d exp %0d", x, y, lat, elat); end
            if (lat < 0) continue;
            tests++;
            if (resp_in_bounds !== inb[0] || resp_index !== 8'(idx) || resp_ch !== ch[0]) begin
                fails++;
                $display("FAIL map_index (%0d,%0d) got inb%0b idx%0d ch%0d exp inb%0d idx%0d ch%0d",
                         x, y, resp_in_bounds, resp_index, resp_ch, inb, idx, ch);
            end
            if (inb == 1) begin
                tests++;
                if (resp_col !== 4'(col) || resp_row !== 4'(row) || resp_off_x !== 10'(offx) || resp_off_y !== 10'(offy)) begin
                    fails++;
                    $display("FAIL map_fields (%0d,%0d) got c%0d r%0d ox%0d oy%0d exp c%0d r%0d ox%0d oy%0d",
                             x, y, resp_col, resp_row, resp_off_x, resp_off_y, col, row, offx, offy);
                end
            end
            accept();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok;
        set_req(0, 100, 180);
        wait_grant(0, ok);
        wait_resp(lat);
        tests++;
        if (!ok || lat !== 3) begin fails++; $display("FAIL bp_latency got ok%0b lat%0d exp lat3", ok, lat); end
        set_req(1, 500, 400);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            tests++;
            if (resp_valid !== 1'b1 || resp_col !== 4'd2 || resp_row !== 4'd2 || resp_index !== 8'd32 || req_ready !== 2'b00) begin
                fails++;
                $display("FAIL bp_hold cyc%0d got v%0b c%0d r%0d idx%0d rdy%b exp v1 c2 r2 idx32 rdy00",
                         i, resp_valid, resp_col, resp_row, resp_index, req_ready);
            end
        end
        req_valid[1] = 1'b0;
        @(posedge Clk); #1;
        accept();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        set_req(0, 619, 459);
        wait_grant(0, ok);
        repeat (5) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        tests++;
        if (resp_valid !== 1'b0 || req_ready !== 2'b00) begin
            fails++; $display("FAIL mid_reset got v%0b rdy%b exp v0 rdy00", resp_valid, req_ready);
        end
        set_req(0, 20, 100);
        set_req(1, 60, 100);
        @(negedge Clk);
        tests++;
        if (req_ready !== 2'b01) begin fails++; $display("FAIL mid_reset_ptr got %b exp 01", req_ready); end
        @(posedge Clk); #1;
        req_valid[0] = 1'b0;
        wait_resp(lat);
        accept();
        wait_grant(1, ok);
        wait_resp(lat);
        tests++;
        if (!ok || lat !== 2 || resp_ch !== 1'b1 || resp_index !== 8'd1) begin
            fails++; $display("FAIL mid_reset_drain got ok%0b lat%0d ch%0d idx%0d exp lat2 ch1 idx1", ok, lat, resp_ch, resp_index);
        end
        accept();
    endtask

    initial begin
        Reset      = 1'b1;
        resp_ready = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        test_reset();
        test_round_robin();
        test_mapping();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
